// File: rtl/tt_sweep_capture.sv
// ============================================================================
//  Module   : tt_sweep_capture
//  Purpose  : Sweeps all 2^N_IN input vectors of a Boolean function block,
//             captures its truth table, counts its ones, and compares the table
//             against an expected one.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tt_sweep_capture #(
    parameter int  N_IN = 7,
    parameter int  LAT  = 0,
    localparam int TT_W = 1 << N_IN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [TT_W-1:0]   expected,
    output logic [N_IN-1:0]   x,
    input  logic              f_in,
    output logic              busy,
    output logic [TT_W-1:0]   tt,
    output logic [N_IN:0]     ones,
    output logic              match,
    output logic              res_valid,
    input  logic              res_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [N_IN:0] c_last_cnt = (N_IN+1)'(TT_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN:0]     r_cnt;
    logic [TT_W-1:0]   r_expected;
    logic [TT_W-1:0]   r_tt;
    logic [N_IN:0]     r_ones;
    logic              r_match;
    logic              r_busy;
    logic              r_res_valid;

    logic              w_busy_st;
    logic              w_smp_vld;
    logic [N_IN-1:0]   w_smp_idx;
    logic              w_smp_en;
    logic              w_last_smp;
    logic [TT_W-1:0]   w_tt_nxt;
    logic [N_IN:0]     w_ones_nxt;

    assign w_busy_st = (r_state == ST_SWEEP) || (r_state == ST_DRAIN);

    // Sample index/valid trail the driven vector by LAT cycles.
    generate
        if (LAT == 0) begin : g_lat0
            assign w_smp_vld = (r_state == ST_SWEEP);
            assign w_smp_idx = r_cnt[N_IN-1:0];
        end else begin : g_latn
            logic [LAT-1:0]  r_vld_pipe;
            logic [N_IN-1:0] r_idx_pipe [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld_pipe <= '0;
                    for (int i = 0; i < LAT; i++) r_idx_pipe[i] <= '0;
                end else if (w_busy_st) begin
                    r_vld_pipe[0] <= (r_state == ST_SWEEP);
                    r_idx_pipe[0] <= r_cnt[N_IN-1:0];
                    for (int i = 1; i < LAT; i++) begin
                        r_vld_pipe[i] <= r_vld_pipe[i-1];
                        r_idx_pipe[i] <= r_idx_pipe[i-1];
                    end
                end else begin
                    // Flush so an aborted sweep cannot leak samples into the next one.
                    r_vld_pipe <= '0;
                    for (int i = 0; i < LAT; i++) r_idx_pipe[i] <= '0;
                end
            end

            assign w_smp_vld = r_vld_pipe[LAT-1];
            assign w_smp_idx = r_idx_pipe[LAT-1];
        end
    endgenerate

    assign w_smp_en   = w_smp_vld && w_busy_st;
    assign w_last_smp = w_smp_en && (w_smp_idx == c_last_cnt[N_IN-1:0]);
    assign w_ones_nxt = r_ones + {{N_IN{1'b0}}, (w_smp_en & f_in)};

    always_comb begin
        w_tt_nxt = r_tt;
        if (w_smp_en) w_tt_nxt[w_smp_idx] = f_in;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SWEEP;
            end
            ST_SWEEP: begin
                if (abort)                    w_state_nxt = ST_IDLE;
                else if (r_cnt == c_last_cnt) w_state_nxt = (LAT == 0) ? ST_HOLD : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)           w_state_nxt = ST_IDLE;
                else if (w_last_smp) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_expected  <= '0;
            r_tt        <= '0;
            r_ones      <= '0;
            r_match     <= 1'b0;
            r_busy      <= 1'b0;
            r_res_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == ST_SWEEP) || (w_state_nxt == ST_DRAIN);
            r_res_valid <= (w_state_nxt == ST_HOLD);
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_tt       <= '0;
                    r_ones     <= '0;
                    r_match    <= 1'b0;
                    r_expected <= expected;
                    r_cnt      <= '0;
                end
            end else begin
                r_tt   <= w_tt_nxt;
                r_ones <= w_ones_nxt;
                if (r_state == ST_SWEEP) r_cnt <= r_cnt + 1'b1;
                // Compare the table including the bit written on this same edge.
                if (w_busy_st && (w_state_nxt == ST_HOLD)) r_match <= (w_tt_nxt == r_expected);
            end
        end
    end

    assign x         = (r_state == ST_SWEEP) ? r_cnt[N_IN-1:0] :
                       (r_state == ST_DRAIN) ? '1 : '0;
    assign busy      = r_busy;
    assign tt        = r_tt;
    assign ones      = r_ones;
    assign match     = r_match;
    assign res_valid = r_res_valid;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep_capture.sv
// ============================================================================
//  Module   : tb_tt_sweep_capture
//  Purpose  : Self-checking bench for tt_sweep_capture (LAT=0 and LAT=2 builds)
//             against a truth-table reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tt_sweep_capture;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         start0 = 1'b0, abort0 = 1'b0, res_ready0 = 1'b1;
    logic [127:0] exp0 = '0;
    logic [6:0]   x0;
    logic         f0, busy0, match0, rv0;
    logic [127:0] tt0;
    logic [7:0]   ones0;

    logic         start2 = 1'b0, abort2 = 1'b0, res_ready2 = 1'b1;
    logic [127:0] exp2 = '0;
    logic [6:0]   x2;
    logic         f2, busy2, match2, rv2;
    logic [127:0] tt2;
    logic [7:0]   ones2;

    logic [127:0] func = '0;
    logic         d1 = 1'b0, d2 = 1'b0;
    bit           sel = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    // Function block under characterisation: a lookup of the bench's table.
    assign f0 = func[x0];
    always @(posedge clk) begin
        d1 <= func[x2];
        d2 <= d1;
    end
    assign f2 = d2;

    tt_sweep_capture #(.N_IN(7), .LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .expected(exp0),
        .x(x0), .f_in(f0), .busy(busy0), .tt(tt0), .ones(ones0), .match(match0),
        .res_valid(rv0), .res_ready(res_ready0)
    );

    tt_sweep_capture #(.N_IN(7), .LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .expected(exp2),
        .x(x2), .f_in(f2), .busy(busy2), .tt(tt2), .ones(ones2), .match(match2),
        .res_valid(rv2), .res_ready(res_ready2)
    );

    wire [6:0]   m_x     = sel ? x2 : x0;
    wire         m_busy  = sel ? busy2 : busy0;
    wire [127:0] m_tt    = sel ? tt2 : tt0;
    wire [7:0]   m_ones  = sel ? ones2 : ones0;
    wire         m_match = sel ? match2 : match0;
    wire         m_rv    = sel ? rv2 : rv0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic set_start(input bit v);
        if (sel) start2 = v; else start0 = v;
    endtask
    task automatic set_abort(input bit v);
        if (sel) abort2 = v; else abort0 = v;
    endtask
    task automatic set_ready(input bit v);
        if (sel) res_ready2 = v; else res_ready0 = v;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full sweep; reference result is the function table itself.
    task automatic do_sweep(input logic [127:0] fn, input logic [127:0] ex, input int lat, input bit ready);
        int k;
        func = fn;
        exp0 = ex;
        exp2 = ex;
        set_ready(ready);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        k = 0;
        while (!m_rv && k < 1000) begin
            if (k < 128)            check("x_sweep", m_x, k);
            else if (k < 128 + lat) check("x_drain", m_x, 127);
            check("busy_run", m_busy, 1);
            @(posedge clk); #1;
            k++;
        end
        check("latency", k, 128 + lat);
        check("tt", m_tt, fn);
        check("ones", m_ones, $countones(fn));
        check("match", m_match, fn == ex);
        check("busy_hold", m_busy, 0);
        if (ready) begin
            @(posedge clk); #1;
            check("rv_drop", m_rv, 0);
        end
    endtask

    initial begin
        logic [127:0] fn, ex;
        int w;
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        check("rst_x", x0, 0);
        check("rst_busy", busy0, 0);
        check("rst_tt", tt0, 0);
        check("rst_ones", ones0, 0);
        check("rst_match", match0, 0);
        check("rst_rv", rv0, 0);
        check("rst_rv2", rv2, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed patterns, LAT=0.
        sel = 1'b0;
        do_sweep({64{2'b10}}, {64{2'b10}}, 0, 1'b1);
        do_sweep(128'h1 << 127, 128'h0, 0, 1'b1);

        // Random tables, expected either exact or with one flipped bit.
        for (int r = 0; r < 4; r++) begin
            fn = rnd128();
            ex = fn;
            if ($urandom_range(0, 1) == 1) ex[$urandom_range(0, 127)] ^= 1'b1;
            do_sweep(fn, ex, 0, 1'b1);
        end

        // Back-pressure: result stays put and start is ignored in HOLD.
        fn = rnd128();
        do_sweep(fn, fn, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            set_start(i[0]);
            @(posedge clk); #1;
            check("bp_rv", m_rv, 1);
            check("bp_busy", m_busy, 0);
            check("bp_tt", m_tt, fn);
            check("bp_ones", m_ones, $countones(fn));
            check("bp_match", m_match, 1);
        end
        set_ready(1'b1);
        set_start(1'b1);
        @(posedge clk); #1;
        check("hs_rv", m_rv, 0);
        check("hs_start_ignored", m_busy, 0);
        @(posedge clk); #1;
        check("start_accepted", m_busy, 1);
        set_start(1'b0);

        // Abort at cnt=37.
        w = 0;
        while (m_x != 7'd37 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("abort_reach37", m_x, 37);
        set_abort(1'b1);
        @(posedge clk); #1;
        set_abort(1'b0);
        check("abort_busy", m_busy, 0);
        check("abort_x", m_x, 0);
        check("abort_match", m_match, 0);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_rv) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("abort_no_rv", seen, 0);
        fn = rnd128();
        do_sweep(fn, fn, 0, 1'b1);

        // Reset mid-sweep at cnt=90.
        func = '1;
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        w = 0;
        while (m_x != 7'd90 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        check("rst_reach90", m_x, 90);
        rst_n = 1'b0;
        #1;
        check("mrst_x", m_x, 0);
        check("mrst_busy", m_busy, 0);
        check("mrst_tt", m_tt, 0);
        check("mrst_ones", m_ones, 0);
        check("mrst_match", m_match, 0);
        check("mrst_rv", m_rv, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fn = 128'h0000_0100_0000_0000_0040_0000_0000_0001;
        do_sweep(fn, fn, 0, 1'b1);

        // LAT=2 build.
        sel = 1'b1;
        do_sweep({64{2'b10}}, {64{2'b10}}, 2, 1'b1);
        for (int r = 0; r < 2; r++) begin
            fn = rnd128();
            ex = (r == 0) ? fn : rnd128();
            do_sweep(fn, ex, 2, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tt_sweep_capture.md
Name:
tt_sweep_capture

Overview:
- Characterisation engine for single-output N-input Boolean functions (default 7-input) built in this codebase.
- It is the driving and reading end of a function block. It drives every input vector 0..2^N-1 onto the function inputs and samples the function output.
- It assembles the full truth table, counts its ones, and compares the result with an expected truth table.
- The result is handed to a consumer over a valid/ready handshake.

Parameters:
- N_IN, 7, number of function inputs; truth table width TT_W = 2^N_IN.
- LAT, 0, clock cycles between driving x and f_in being valid for that x (0 = purely combinational function).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; acted on only in IDLE.
- abort  input  1  cancel a sweep in SWEEP/DRAIN.
- expected  input  TT_W  reference truth table; registered on an accepted start.
- x  output  N_IN  input vector driven to the function; x[0] = x0 (LSB).
- f_in  input  1  function output.
- busy  output  1  high in SWEEP and DRAIN.
- tt  output  TT_W  captured truth table; bit i = f(x=i).
- ones  output  N_IN+1  popcount of tt.
- match  output  1  tt == registered expected.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; x=0; busy=0; tt=0; ones=0; match=0; res_valid=0; internal counters and registered expected = 0. This applies mid-sweep too: no partial result, no res_valid.
- States: IDLE, SWEEP, DRAIN, HOLD.
- IDLE:
  - x=0.
  - At a clock edge with start=1: clear tt and ones, register expected, set cnt=0, go to SWEEP.
- SWEEP:
  - x=cnt; cnt increments by 1 per cycle.
  - In the cycle after x reaches TT_W-1: go to DRAIN if LAT>0, else to HOLD.
  - Sampling: f_in present in the cycle that is LAT cycles after x=i was driven is written into tt[i] at that cycle's closing edge. When f_in=1, ones increments at the same edge.
  - The sample index comes from a LAT-deep delayed copy of cnt. With LAT=0, tt[i] is captured at the edge ending the cycle in which x=i.
- DRAIN:
  - x holds TT_W-1.
  - Lasts exactly LAT cycles, capturing the remaining samples, then goes to HOLD.
- HOLD:
  - res_valid=1.
  - match is registered on entry (tt compared after its final bit is written).
  - tt, ones and match are stable while res_valid=1.
  - At an edge with res_valid & res_ready: res_valid=0, go to IDLE.
  - tt, ones and match keep their values until the next accepted start.
- Latency: res_valid first goes high exactly TT_W+LAT cycles after the start edge (128 for the defaults). With res_ready held high it drops one cycle later.
- start:
  - Ignored in SWEEP, DRAIN and HOLD.
  - start asserted in the same cycle as the HOLD->IDLE handshake is not accepted. It is accepted from the following IDLE cycle.
- abort:
  - In SWEEP/DRAIN, go to IDLE at the next edge: x=0, busy=0, res_valid stays 0, tt/ones keep their partial values, match=0.
  - Ignored in IDLE and HOLD.
  - If start and abort are both high in IDLE, start wins.
- Width rules:
  - cnt is N_IN+1 bits so terminal detection needs no wrap.
  - x is cnt[N_IN-1:0].
  - ones never overflows because its maximum is TT_W, which fits in N_IN+1 bits.
- busy is registered and high exactly for the SWEEP+DRAIN cycles.

Test Plan:
- Default params, f_in = x[0] (combinational), expected = 128'hAAAA...AAAA -> tt=128'hAAAA...AAAA, ones=64, match=1, res_valid rises 128 cycles after the start edge.
- f_in = AND of x[6:0], expected=0 -> tt bit127 only (128'h8000...0000), ones=1, match=0.
- LAT=2, f_in = x[0] delayed two cycles by a bench register -> tt=128'hAAAA...AAAA, ones=64, DRAIN lasts 2 cycles, res_valid at cycle 130.
- Back-pressure: hold res_ready=0 for 10 cycles in HOLD, pulse start meanwhile -> tt/ones/match stable, start ignored; res_ready=1 -> res_valid falls next edge, next start accepted.
- abort at cnt=37 -> IDLE next edge, busy=0, x=0, res_valid never asserts, match=0. A new start produces a full, correct sweep.
- rst_n low at cnt=90, then released and start issued -> all outputs are zero during reset, and the next sweep's tt contains no bits from the aborted run.
